// File: rtl/ad7476a_averager.sv
// AD7476A conversion pacer and sample averager. It requests conversions at a fixed rate,
// averages 2^LOG2_AVG samples and holds the truncated mean in a valid/ready output register.
module ad7476a_averager #(
  parameter int unsigned CLK_FREQ_HZ    = 100_000_000,
  parameter int unsigned SAMPLE_RATE_HZ = 1_000_000,
  parameter int unsigned LOG2_AVG       = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        enable_i,
  output logic        request_o,
  input  logic [11:0] adc_data_i,
  input  logic        adc_valid_i,
  output logic [11:0] avg_data_o,
  output logic        avg_valid_o,
  input  logic        avg_ready_i,
  output logic        overrun_o,
  output logic        timeout_o
);

  localparam int unsigned DATA_W = 12;
  localparam int unsigned PERIOD = CLK_FREQ_HZ / SAMPLE_RATE_HZ;
  localparam int unsigned TMR_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int unsigned ACC_W  = DATA_W + LOG2_AVG;
  localparam int unsigned CNT_W  = (LOG2_AVG > 0) ? LOG2_AVG : 1;
  localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES + 1);

  if (PERIOD < 2) begin : g_bad_period
    $error("ad7476a_averager: CLK_FREQ_HZ / SAMPLE_RATE_HZ must be at least 2");
  end
  if (LOG2_AVG > 8) begin : g_bad_log2_avg
    $error("ad7476a_averager: LOG2_AVG must be in 0..8");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("ad7476a_averager: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, ARMED, BUSY} state_e;

  state_e              state_q;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [TO_W-1:0]     to_cnt_q;
  logic [ACC_W-1:0]    acc_q, acc_d, sum_c;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   avg_q, avg_d;
  logic                avg_valid_q, avg_valid_d;
  logic                overrun_q, overrun_d;
  logic                request_q, timeout_q;
  logic                tick_c, accept_c, last_c, done_c, handshake_c, load_c;

  assign tick_c      = (timer_q == TMR_W'(PERIOD - 1));
  assign accept_c    = enable_i && adc_valid_i && (state_q == BUSY);
  assign last_c      = (cnt_q == CNT_W'((2 ** LOG2_AVG) - 1));
  assign done_c      = accept_c && last_c;
  assign sum_c       = acc_q + ACC_W'(adc_data_i);
  assign handshake_c = avg_valid_q && avg_ready_i;
  assign load_c      = done_c && (!avg_valid_q || avg_ready_i);

  // Rate timer, accumulator and output register next state.
  always_comb begin
    timer_d     = '0;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    avg_d       = avg_q;
    avg_valid_d = avg_valid_q;
    overrun_d   = overrun_q;
    if (enable_i) begin
      timer_d = tick_c ? '0 : timer_q + 1'b1;
    end
    if (!enable_i) begin
      acc_d     = '0;
      cnt_d     = '0;
      overrun_d = 1'b0;
    end else if (accept_c) begin
      if (last_c) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = sum_c;
        cnt_d = cnt_q + 1'b1;
      end
    end
    if (load_c) begin
      avg_d       = DATA_W'(sum_c >> LOG2_AVG);
      avg_valid_d = 1'b1;
    end else if (handshake_c) begin
      avg_valid_d = 1'b0;
    end
    // A full register with no handshake drops the new result.
    if (done_c && !load_c) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      timer_q     <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      avg_q       <= '0;
      avg_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      timer_q     <= timer_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      avg_q       <= avg_d;
      avg_valid_q <= avg_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  // Request/response sequencing; a sample beats a same-cycle timeout.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      request_q <= 1'b0;
      timeout_q <= 1'b0;
      to_cnt_q  <= '0;
    end else begin
      request_q <= 1'b0;
      timeout_q <= 1'b0;
      if (!enable_i) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: state_q <= ARMED;
          ARMED: begin
            if (tick_c) begin
              state_q   <= BUSY;
              request_q <= 1'b1;
              to_cnt_q  <= '0;
            end
          end
          BUSY: begin
            if (adc_valid_i) begin
              state_q <= ARMED;
            end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
              state_q   <= ARMED;
              timeout_q <= 1'b1;
            end else begin
              to_cnt_q <= to_cnt_q + 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign request_o   = request_q;
  assign timeout_o   = timeout_q;
  assign avg_data_o  = avg_q;
  assign avg_valid_o = avg_valid_q;
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_ad7476a_averager.sv
// Self-checking bench for ad7476a_averager: vector table, random averages against a
// sum-and-shift model, and hand sequences for timeout, overrun, enable drop and reset.
module tb_ad7476a_averager;

  localparam int unsigned PERIOD = 100;
  localparam int unsigned TMO    = 50;

  typedef struct {
    logic [3:0][11:0] s;
    logic [11:0]      exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        adc_valid = 1'b0;
  logic        ready = 1'b1;
  logic [11:0] adc_data = '0;
  logic        request, avg_valid, overrun, timeout;
  logic [11:0] avg_data;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_req = -1;
  int first_ref = -1;
  int n;
  int rsum;
  logic [3:0][11:0] rs;
  vec_t tbl[5];

  ad7476a_averager #(
    .CLK_FREQ_HZ(100_000_000),
    .SAMPLE_RATE_HZ(1_000_000),
    .LOG2_AVG(2),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i(clk),
    .rst_n_i(rst_n),
    .enable_i(enable),
    .request_o(request),
    .adc_data_i(adc_data),
    .adc_valid_i(adc_valid),
    .avg_data_o(avg_data),
    .avg_valid_o(avg_valid),
    .avg_ready_i(ready),
    .overrun_o(overrun),
    .timeout_o(timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Waits (bounded) for a request pulse; checks spacing/first-request timing and width.
  task automatic wait_req(input string name);
    int k;
    k = 0;
    while (request !== 1'b1 && k < 3 * PERIOD) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (request !== 1'b1) begin
      failures++;
      $display("FAIL %s_request_wait actual=none required=request", name);
    end else begin
      if (last_req >= 0) chk({name, "_spacing"}, cyc - last_req, PERIOD);
      if (first_ref >= 0) chk({name, "_first_req"}, cyc - first_ref, (PERIOD - 1) + 1);
      first_ref = -1;
      last_req  = cyc;
      @(negedge clk);
      chk({name, "_req_width"}, request, 0);
    end
  endtask

  task automatic strobe(input logic [11:0] d, input int delay);
    repeat (delay - 1) @(negedge clk);
    adc_data  = d;
    adc_valid = 1'b1;
    @(negedge clk);
    adc_valid = 1'b0;
    adc_data  = 12'($urandom_range(0, 4095));
  endtask

  task automatic feed(input string name, input logic [3:0][11:0] s, input int cnt, input bit rnd);
    for (int i = 0; i < cnt; i++) begin
      wait_req(name);
      strobe(s[i], rnd ? int'($urandom_range(1, 30)) : 5);
    end
  endtask

  initial begin
    tbl[0].s = {12'd401, 12'd300, 12'd200, 12'd100};   tbl[0].exp = 12'd250;
    tbl[1].s = {12'd4095, 12'd4095, 12'd4095, 12'd4095}; tbl[1].exp = 12'd4095;
    tbl[2].s = {12'd3, 12'd0, 12'd0, 12'd0};           tbl[2].exp = 12'd0;
    tbl[3].s = {12'd4, 12'd3, 12'd2, 12'd1};           tbl[3].exp = 12'd2;
    tbl[4].s = {12'd11, 12'd9, 12'd8, 12'd7};          tbl[4].exp = 12'd8;

    repeat (3) @(negedge clk);
    chk("rst_request", request, 0);
    chk("rst_avg_valid", avg_valid, 0);
    chk("rst_avg_data", avg_data, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_timeout", timeout, 0);

    rst_n = 1'b1;
    enable = 1'b1;
    first_ref = cyc;
    last_req = -1;

    for (int v = 0; v < 5; v++) begin
      feed($sformatf("tbl%0d", v), tbl[v].s, 4, 1'b0);
      chk($sformatf("tbl%0d_valid", v), avg_valid, 1);
      chk($sformatf("tbl%0d_data", v), avg_data, tbl[v].exp);
      chk($sformatf("tbl%0d_overrun", v), overrun, 0);
      @(negedge clk);
      chk($sformatf("tbl%0d_consumed", v), avg_valid, 0);
    end

    for (int r = 0; r < 6; r++) begin
      rsum = 0;
      for (int i = 0; i < 4; i++) begin
        rs[i] = 12'($urandom_range(0, 4095));
        rsum += int'(rs[i]);
      end
      feed("rnd", rs, 4, 1'b1);
      chk("rnd_valid", avg_valid, 1);
      chk("rnd_data", avg_data, rsum / 4);
      @(negedge clk);
      chk("rnd_consumed", avg_valid, 0);
    end

    // Unanswered request between two real samples and two more.
    rs = {12'd0, 12'd0, 12'd40, 12'd40};
    feed("tmo_pre", rs, 2, 1'b0);
    wait_req("tmo");
    n = 1;
    while (timeout !== 1'b1 && n < 4 * TMO) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_latency", n, TMO);
    @(negedge clk);
    chk("tmo_width", timeout, 0);
    chk("tmo_no_result", avg_valid, 0);
    rs = {12'd0, 12'd0, 12'd44, 12'd40};
    feed("tmo_post", rs, 2, 1'b0);
    chk("tmo_avg_valid", avg_valid, 1);
    chk("tmo_avg_data", avg_data, 41);
    @(negedge clk);

    // Overrun with the consumer stalled.
    ready = 1'b0;
    rs = {12'd10, 12'd10, 12'd10, 12'd10};
    feed("ovr_a", rs, 4, 1'b0);
    chk("ovr_a_valid", avg_valid, 1);
    chk("ovr_a_data", avg_data, 10);
    chk("ovr_a_overrun", overrun, 0);
    rs = {12'd20, 12'd20, 12'd20, 12'd20};
    feed("ovr_b", rs, 4, 1'b0);
    chk("ovr_b_valid", avg_valid, 1);
    chk("ovr_b_data_kept", avg_data, 10);
    chk("ovr_b_overrun", overrun, 1);
    ready = 1'b1;
    chk("ovr_hs_data", avg_data, 10);
    @(negedge clk);
    chk("ovr_hs_cleared", avg_valid, 0);
    chk("ovr_still_set", overrun, 1);

    // Enable drop discards a partial average and clears overrun.
    rs = {12'd0, 12'd0, 12'd1000, 12'd1000};
    feed("en_pre", rs, 2, 1'b0);
    enable = 1'b0;
    @(negedge clk);
    chk("en_overrun_clr", overrun, 0);
    repeat (10) @(negedge clk);
    chk("en_idle_request", request, 0);
    enable = 1'b1;
    first_ref = cyc;
    last_req = -1;
    rs = {12'd8, 12'd8, 12'd8, 12'd8};
    feed("en_post", rs, 4, 1'b0);
    chk("en_avg_valid", avg_valid, 1);
    chk("en_avg_data", avg_data, 8);
    @(negedge clk);

    // Asynchronous reset while a request is outstanding.
    ready = 1'b0;
    rs = {12'd5, 12'd5, 12'd5, 12'd5};
    feed("rs_a", rs, 4, 1'b0);
    feed("rs_b", rs, 4, 1'b0);
    chk("rs_pre_overrun", overrun, 1);
    n = 0;
    while (request !== 1'b1 && n < 3 * PERIOD) begin
      @(negedge clk);
      n++;
    end
    chk("rs_pre_request", request, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rs_async_request", request, 0);
    chk("rs_async_avg_valid", avg_valid, 0);
    chk("rs_async_overrun", overrun, 0);
    chk("rs_async_timeout", timeout, 0);
    chk("rs_async_avg_data", avg_data, 0);
    ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    first_ref = cyc;
    last_req = -1;
    wait_req("rs_post");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
